// File: rtl/ctrl_acceso_arb_if.sv
// Lane-side handshake bundle for the shared door controller.
// The controller takes the slave view; lane logic or a bench takes the master view.
interface ctrl_acceso_arb_if #(
  parameter int unsigned N_REQ = 2
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] alm_in;
  logic             alm_ack;
  logic [N_REQ-1:0] gnt;
  logic             door_open;
  logic             alarm;
  logic             busy;

  modport master (
    output req, alm_in, alm_ack,
    input  gnt, door_open, alarm, busy
  );

  modport slave (
    input  req, alm_in, alm_ack,
    output gnt, door_open, alarm, busy
  );
endinterface

// File: rtl/ctrl_acceso_arb.sv
// Round-robin supervisor for one door actuator shared by N_REQ lanes:
// timed opening, guard interval, and alarm lockdown until acknowledged.
module ctrl_acceso_arb #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned T_OPEN  = 8,
  parameter int unsigned T_GUARD = 4
) (
  input  logic             clk,
  input  logic             reset,
  ctrl_acceso_arb_if.slave bus
);

  localparam int unsigned T_MAX = (T_OPEN > T_GUARD) ? T_OPEN : T_GUARD;
  localparam int unsigned CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int unsigned LW    = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    GUARD = 2'd2,
    LOCK  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [LW-1:0]    last, last_nxt;
  logic [N_REQ-1:0] gnt_q, gnt_nxt;
  logic [LW-1:0]    sel;
  logic             sel_vld;
  logic             any_alm;

  assign any_alm = |bus.alm_in;

  // Round-robin pick: first requesting lane searching upward from last+1, wrapping.
  always_comb begin : rr_pick
    logic [LW-1:0] cand;
    sel     = '0;
    sel_vld = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = LW'((32'(last) + k) % N_REQ);
      if (!sel_vld && bus.req[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
  end

  // State register; the pointer resets to the top lane so lane 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= LW'(N_REQ - 1);
      gnt_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
      gnt_q <= gnt_nxt;
    end
  end

  // Next-state logic; a lane alarm outranks every other transition.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    gnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (any_alm) begin
          state_nxt = LOCK;
          cnt_nxt   = '0;
        end else if (sel_vld) begin
          state_nxt = OPEN;
          gnt_nxt   = N_REQ'(1) << sel;
          cnt_nxt   = CW'(T_OPEN - 1);
          last_nxt  = sel;
        end
      end
      OPEN: begin
        if (any_alm) begin
          state_nxt = LOCK;
          cnt_nxt   = '0;
        end else if (!bus.req[last] || cnt == '0) begin
          state_nxt = GUARD;
          cnt_nxt   = CW'(T_GUARD - 1);
        end else begin
          gnt_nxt = gnt_q;
          cnt_nxt = cnt - CW'(1);
        end
      end
      GUARD: begin
        if (any_alm) begin
          state_nxt = LOCK;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      LOCK: begin
        if (bus.alm_ack && !any_alm) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decoded purely from registered state and grant.
  always_comb begin
    bus.gnt       = '0;
    bus.door_open = 1'b0;
    bus.alarm     = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      OPEN: begin
        bus.gnt       = gnt_q;
        bus.door_open = 1'b1;
        bus.busy      = 1'b1;
      end
      GUARD: bus.busy  = 1'b1;
      LOCK:  bus.alarm = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/ctrl_acceso_arb.md
Name: ctrl_acceso_arb

Overview:
- Supervisory controller for one shared door actuator serving N_REQ access lanes; each lane runs its own sensor-sequencing FSM.
- Lanes raise req; controller grants one lane at a time, round-robin, and opens the door for a bounded time.
- A guard interval follows every opening before the next grant.
- Any lane alarm forces lockdown: door closed, global alarm latched until operator acknowledge.

Parameters:
- N_REQ, 2, number of lanes; legal 2..4.
- T_OPEN, 8, door-open cycles per grant; >=1.
- T_GUARD, 4, door-closed cycles after each opening; >=1.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- req  input  N_REQ  per-lane access request, level; bit i = lane i.
- alm_in  input  N_REQ  per-lane alarm from lane FSM, level.
- alm_ack  input  1  operator acknowledge, level, sampled only in LOCK.
- gnt  output  N_REQ  one-hot grant to the lane being served; zero otherwise.
- door_open  output  1  door actuator drive.
- alarm  output  1  global alarm indicator.
- busy  output  1  high in OPEN or GUARD.

Behaviour:
- Reset (reset=1 at an edge):
  - state=IDLE; gnt=0, door_open=0, alarm=0, busy=0; counter=0.
  - Round-robin pointer set so lane 0 has top priority.
  - Reset has priority over every other input in every state, including mid-OPEN and LOCK.
- Outputs are decoded from registered state and the registered grant; there is no combinational path from inputs to outputs.
- States: IDLE, OPEN, GUARD, LOCK.
- Alarm rule: if alm_in != 0 at an edge in IDLE, OPEN or GUARD, next state=LOCK. This has priority over every other transition.
- IDLE:
  - Outputs all 0.
  - If req != 0: select lane by round-robin, searching upward from (last_granted+1) mod N_REQ with wrap.
  - Next state=OPEN; gnt=one-hot(selected); counter=T_OPEN-1; last_granted=selected.
  - Latency: req sampled at edge k, so gnt and door_open are high from edge k onward.
- OPEN:
  - door_open=1, busy=1, gnt=one-hot(last_granted).
  - If the granted lane's req=0 at an edge (early release), next state=GUARD.
  - Else if counter=0, next state=GUARD. Otherwise counter decrements.
  - Entering GUARD: gnt=0, counter=T_GUARD-1.
  - door_open is high for exactly T_OPEN cycles when req is held.
  - Requests from other lanes are ignored during OPEN and GUARD; they are not queued beyond their level.
- GUARD:
  - door_open=0, gnt=0, busy=1.
  - Counter decrements; at 0, next state=IDLE.
  - Lasts exactly T_GUARD cycles; no grant can occur during GUARD.
- LOCK:
  - alarm=1, door_open=0, gnt=0, busy=0.
  - Exit to IDLE only when alm_ack=1 AND alm_in=0 at the same edge.
  - If alm_ack=1 while any alm_in is still set, remain in LOCK; acknowledge is not remembered.
  - Round-robin pointer is preserved across LOCK.
- Simultaneous events:
  - Alarm plus counter expiry: LOCK wins.
  - Early release plus counter=0: single transition to GUARD.
- Counter width: clog2(max(T_OPEN,T_GUARD)), minimum 1 bit.
- gnt is always one-hot or zero, never multi-hot.
- Unused or illegal state encodings: next state=IDLE with outputs 0.

Test Plan:
- Reset check: assert reset 2 cycles with random req/alm_in -> gnt=00, door_open=0, alarm=0, busy=0. First grant with req=11 goes to lane 0.
- Single lane, N_REQ=2, T_OPEN=8, T_GUARD=4, req=01 held -> gnt=01 and door_open=1 for exactly 8 cycles, then 4 cycles door_open=0/busy=1, then regrant to lane 0 the cycle after returning to IDLE.
- Fairness, req=11 held for 50 cycles -> grants alternate 01,10,01,10. Each grant lasts 8 cycles open plus 4 guard; no overlap; gnt never 11.
- Early release, req=10 then drop req[1] on 3rd open cycle -> door_open falls the next cycle (3 open cycles total), then 4 guard cycles, then IDLE.
- Lockdown:
  - Pulse alm_in=10 on the 5th OPEN cycle -> next cycle door_open=0, gnt=00, alarm=1.
  - alm_ack=1 with alm_in=10 -> stays LOCK.
  - alm_in=00 with alm_ack=1 -> IDLE, alarm=0. The following grant goes to the lane after the last granted.
- Reset mid-OPEN: reset=1 on the 4th OPEN cycle -> next cycle all outputs 0, state IDLE. With req=11, the next grant is lane 0.
